core_c1_trap_ctrl: RTL and testbench



---
 rtl/core_c1_trap_ctrl.sv | 136 +++++++++++++
 tb/tb_core_c1_trap_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_c1_trap_ctrl.sv
// Trap sequencer for the C1 CSR unit: arbitrates exceptions and machine interrupts,
// fires a one-cycle trap pulse at a legal boundary, then holds the pipeline in flush.
module core_c1_trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_msoft,
  input  logic       irq_mtime,
  input  logic       irq_mext,
  input  logic [2:0] mie_bits,
  input  logic       mstatus_mie,
  input  logic       exc_valid,
  input  logic [7:0] exc_code,
  input  logic       instr_retire,
  input  logic       mret_valid,
  output logic       in_exception,
  output logic       in_interrupt,
  output logic [7:0] in_exception_code,
  output logic [7:0] in_interrupt_code,
  output logic       flush_hold,
  output logic [2:0] irq_pending
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CODE_W  = 8;
  localparam logic [CODE_W-1:0] CODE_MSOFT = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_MTIME = CODE_W'(7);
  localparam logic [CODE_W-1:0] CODE_MEXT  = CODE_W'(11);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  logic [2:0]        w_irq_raw;
  logic [2:0]        w_irq_sync;
  logic [2:0]        w_irq_en_pend;
  logic              w_irq_any;
  logic [CODE_W-1:0] w_irq_code;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_exception;
  logic              r_in_interrupt;
  logic [CODE_W-1:0] r_exc_code;
  logic [CODE_W-1:0] r_irq_code;
  logic              r_flush_hold;

  // Bit order {mext, mtime, msoft} matches mie_bits and irq_pending.
  assign w_irq_raw = {irq_mext, irq_mtime, irq_msoft};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_irq_sync = w_irq_raw;
  end else begin : g_sync
    logic [2:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
      end else begin
        r_sync[0] <= w_irq_raw;
        for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      end
    end

    assign w_irq_sync = r_sync[SYNC_STAGES-1];
  end

  assign w_irq_en_pend = w_irq_sync & mie_bits & {3{mstatus_mie}};
  assign w_irq_any     = |w_irq_en_pend;

  // Fixed priority: mext, then msoft, then mtime.
  always_comb begin
    w_irq_code = CODE_MTIME;
    if (w_irq_en_pend[2])      w_irq_code = CODE_MEXT;
    else if (w_irq_en_pend[0]) w_irq_code = CODE_MSOFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_in_exception <= 1'b0;
      r_in_interrupt <= 1'b0;
      r_exc_code     <= '0;
      r_irq_code     <= '0;
      r_flush_hold   <= 1'b0;
    end else begin
      r_in_exception <= 1'b0;
      r_in_interrupt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_flush_hold <= 1'b0;
          if (exc_valid) begin
            r_state        <= ST_FIRE;
            r_in_exception <= 1'b1;
            r_exc_code     <= exc_code;
          end else if (instr_retire && !mret_valid && w_irq_any) begin
            r_state        <= ST_FIRE;
            r_in_interrupt <= 1'b1;
            r_irq_code     <= w_irq_code;
          end
        end
        ST_FIRE: begin
          r_state      <= ST_FLUSH;
          r_flush_hold <= 1'b1;
          r_cnt        <= CNT_W'(FLUSH_CYCLES - 1);
        end
        ST_FLUSH: begin
          // Squashed instructions cannot raise traps while the hold is up.
          if (r_cnt == '0) begin
            r_state      <= ST_IDLE;
            r_flush_hold <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_flush_hold <= 1'b0;
        end
      endcase
    end
  end

  assign in_exception      = r_in_exception;
  assign in_interrupt      = r_in_interrupt;
  assign in_exception_code = r_exc_code;
  assign in_interrupt_code = r_irq_code;
  assign flush_hold        = r_flush_hold;
  assign irq_pending       = w_irq_sync;

endmodule

// File: tb/tb_core_c1_trap_ctrl.sv
// Scoreboard bench for core_c1_trap_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-indexed behavioural model of trap timing.
module tb_core_c1_trap_ctrl;

  localparam int FC   = 4;
  localparam int SS   = 2;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq_msoft = 1'b0, irq_mtime = 1'b0, irq_mext = 1'b0;
  logic [2:0] mie_bits = 3'b000;
  logic       mstatus_mie = 1'b0;
  logic       exc_valid = 1'b0;
  logic [7:0] exc_code = 8'h00;
  logic       instr_retire = 1'b0;
  logic       mret_valid = 1'b0;
  logic       in_exception, in_interrupt, flush_hold;
  logic [7:0] in_exception_code, in_interrupt_code;
  logic [2:0] irq_pending;

  core_c1_trap_ctrl #(.FLUSH_CYCLES(FC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .irq_msoft(irq_msoft), .irq_mtime(irq_mtime), .irq_mext(irq_mext),
    .mie_bits(mie_bits), .mstatus_mie(mstatus_mie),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .instr_retire(instr_retire), .mret_valid(mret_valid),
    .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_exception_code(in_exception_code), .in_interrupt_code(in_interrupt_code),
    .flush_hold(flush_hold), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int cyc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_exc;
    logic [7:0] code;
  } trap_t;

  trap_t      sb[$];
  logic [2:0] pins  [NCYC];
  bit         rst_h [NCYC];
  bit         exp_flush [NCYC];
  logic [7:0] exp_ecode [NCYC];
  logic [7:0] exp_icode [NCYC];
  int         idle_from = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Staged stimulus, applied just after each rising edge.
  logic [2:0] g_irq = 3'b000, g_mie = 3'b000;
  logic       g_mst = 1'b0, g_exc = 1'b0, g_ret = 1'b0, g_mret = 1'b0, g_rst = 1'b1;
  logic [7:0] g_ec = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Synchronized level seen in cycle c: the pin value SS cycles earlier, unless a reset intervened.
  function automatic logic [2:0] sync_at(input int c);
    if (c - SS < 0) return 3'b000;
    for (int k = c - SS; k < c; k++) if (rst_h[k]) return 3'b000;
    return pins[c - SS];
  endfunction

  task automatic fire(input int c, input bit is_exc, input logic [7:0] code);
    trap_t t;
    t.cyc = c + 1; t.is_exc = is_exc; t.code = code;
    sb.push_back(t);
    for (int k = c + 2; k <= c + 1 + FC && k < NCYC; k++) exp_flush[k] = 1'b1;
    for (int k = c + 1; k < NCYC; k++) begin
      if (is_exc) exp_ecode[k] = code;
      else        exp_icode[k] = code;
    end
    idle_from = c + 2 + FC;
  endtask

  task automatic model(input int c);
    logic [2:0] pend;
    if (g_rst) begin
      for (int k = c + 1; k < NCYC; k++) begin
        exp_flush[k] = 1'b0; exp_ecode[k] = 8'h00; exp_icode[k] = 8'h00;
      end
      while (sb.size() > 0 && sb[sb.size()-1].cyc > c) void'(sb.pop_back());
      idle_from = c + 1;
      return;
    end
    if (c < idle_from) return;
    pend = sync_at(c) & g_mie & {3{g_mst}};
    if (g_exc) fire(c, 1'b1, g_ec);
    else if (g_ret && !g_mret && pend != 3'b000)
      fire(c, 1'b0, pend[2] ? 8'd11 : (pend[0] ? 8'd3 : 8'd7));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst = g_rst;
      {irq_mext, irq_mtime, irq_msoft} = g_irq;
      mie_bits = g_mie; mstatus_mie = g_mst;
      exc_valid = g_exc; exc_code = g_ec;
      instr_retire = g_ret; mret_valid = g_mret;
      pins[cyc] = g_irq;
      rst_h[cyc] = g_rst;
      model(cyc);
    end
  endtask

  // Monitor: pops an expected trap whenever a pulse appears, and checks steady outputs each cycle.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_pulse_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (in_exception || in_interrupt) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", {in_exception, in_interrupt}, 2'b00);
        end else begin
          trap_t e;
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_kind", {in_exception, in_interrupt}, e.is_exc ? 2'b10 : 2'b01);
          chk("pulse_code", e.is_exc ? in_exception_code : in_interrupt_code, e.code);
        end
      end
      chk("flush_hold", flush_hold, exp_flush[cyc]);
      chk("exc_code_out", in_exception_code, exp_ecode[cyc]);
      chk("irq_code_out", in_interrupt_code, exp_icode[cyc]);
      chk("irq_pending", irq_pending, sync_at(cyc));
      chk("pulse_with_flush", (in_exception | in_interrupt) & flush_hold, 1'b0);
      chk("both_pulses", in_exception & in_interrupt, 1'b0);
    end
  end

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      pins[k] = 3'b000; rst_h[k] = 1'b0; exp_flush[k] = 1'b0;
      exp_ecode[k] = 8'h00; exp_icode[k] = 8'h00;
    end
    run(3);
    g_rst = 1'b0; g_mie = 3'b111; g_mst = 1'b1;
    run(3);

    // Single exception.
    g_exc = 1'b1; g_ec = 8'h02; run(1);
    g_exc = 1'b0; run(8);

    // Interrupt priority: mext, then msoft, then mtime.
    g_irq = 3'b111; run(3);
    g_ret = 1'b1; run(1); g_ret = 1'b0; run(8);
    g_irq = 3'b011; run(3);
    g_ret = 1'b1; run(1); g_ret = 1'b0; run(8);
    g_irq = 3'b010; run(3);
    g_ret = 1'b1; run(1); g_ret = 1'b0; run(8);

    // Exception beats a qualifying mtime boundary; mtime follows later.
    g_exc = 1'b1; g_ec = 8'h0B; g_ret = 1'b1; run(1);
    g_exc = 1'b0; g_ret = 1'b0; run(8);
    g_ret = 1'b1; run(1); g_ret = 1'b0; run(8);
    g_irq = 3'b000; run(3);

    // Gating by mstatus_mie, mie bit and mret.
    g_irq = 3'b001; run(3);
    g_mst = 1'b0; g_ret = 1'b1; run(1); g_ret = 1'b0; run(2);
    g_mst = 1'b1; g_mie = 3'b110; g_ret = 1'b1; run(1); g_ret = 1'b0; run(2);
    g_mie = 3'b111; g_mret = 1'b1; g_ret = 1'b1; run(1);
    g_mret = 1'b0; g_ret = 1'b0; run(2);
    g_ret = 1'b1; run(1); g_ret = 1'b0; run(8);
    g_irq = 3'b000; run(3);

    // Exceptions held through FIRE and FLUSH are squashed.
    g_exc = 1'b1; g_ec = 8'h05; run(1);
    g_ec = 8'h06; run(FC + 1);
    g_exc = 1'b0; run(8);

    // Reset in the middle of FLUSH, then a fresh exception.
    g_exc = 1'b1; g_ec = 8'h07; run(1);
    g_exc = 1'b0; run(3);
    g_rst = 1'b1; run(1);
    g_rst = 1'b0; run(2);
    g_exc = 1'b1; g_ec = 8'h09; run(1);
    g_exc = 1'b0; run(8);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(15) == 0) g_irq[b] = ~g_irq[b];
      if ($urandom_range(31) == 0) g_mie = 3'($urandom);
      g_mst  = ($urandom_range(7) != 0);
      g_exc  = ($urandom_range(19) == 0);
      g_ec   = 8'($urandom);
      g_ret  = ($urandom_range(1) == 1);
      g_mret = ($urandom_range(7) == 0);
      g_rst  = ($urandom_range(199) == 0);
      run(1);
    end

    g_irq = 3'b000; g_exc = 1'b0; g_ret = 1'b0; g_mret = 1'b0; g_rst = 1'b0;
    run(12);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
